// File: rtl/fabric_ccff_loader_if.sv
// Configuration word stream between a bitstream source and the loader.
// The source drives data/valid, the loader answers with ready.
interface fabric_ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/fabric_ccff_loader.sv
// Serialises configuration words MSB-first into a fabric ccff chain.
// Counts shifted bits, stops at CHAIN_LEN, folds ccff_tail into a parity.
module fabric_ccff_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 26,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset_n,
  input  logic                   start,
  input  logic                   abort,
  fabric_ccff_loader_if.slave    cfg,
  output logic                   ccff_head,
  output logic                   ccff_clk_en,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic                   tail_parity,
  output logic [CNT_W-1:0]       bit_count
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WORD_BITS = WC_W'(WORD_W);
  localparam logic [WC_W-1:0]  ONE_LEFT  = WC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] sreg;
  logic [WC_W-1:0]   wcnt;
  logic              ready;
  logic              accept;
  logic              shift_en;
  logic              launch;
  logic              last_bit;
  logic              word_end;

  assign cfg.cfg_ready = ready;

  assign launch   = (state == IDLE) && start;
  assign accept   = ready && cfg.cfg_valid;
  assign shift_en = (state == SHIFT) && !abort;
  assign last_bit = (bit_count == LAST_BIT);
  assign word_end = (wcnt == ONE_LEFT);

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; abort only bites while a load is active.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: begin
        if (start) state_nx = FETCH;
      end
      state == FETCH: begin
        if (abort)               state_nx = IDLE;
        else if (cfg.cfg_valid)  state_nx = SHIFT;
      end
      state == SHIFT: begin
        if (abort)         state_nx = IDLE;
        else if (last_bit) state_nx = DONE;
        else if (word_end) state_nx = FETCH;
      end
      state == DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; abort kills ready and the chain clock in the same cycle.
  always_comb begin
    ready       = 1'b0;
    ccff_clk_en = 1'b0;
    ccff_head   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        busy = 1'b0;
      end
      state == FETCH: begin
        ready = !abort;
        busy  = 1'b1;
      end
      state == SHIFT: begin
        ccff_clk_en = !abort;
        ccff_head   = !abort && sreg[WORD_W-1];
        busy        = 1'b1;
      end
      state == DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Word shift register and bit-in-word counter.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      sreg <= '0;
      wcnt <= '0;
    end else if (accept) begin
      sreg <= cfg.cfg_data;
      wcnt <= WORD_BITS;
    end else if (shift_en) begin
      sreg <= sreg << 1;
      wcnt <= wcnt - ONE_LEFT;
    end
  end

  // Load statistics; held after DONE/abort until the next start.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else if (launch) begin
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else if (shift_en) begin
      bit_count   <= bit_count + CNT_W'(1);
      tail_parity <= tail_parity ^ ccff_tail;
    end
  end

  a_head_quiet: assert property (
    @(posedge prog_clk) disable iff (!prog_reset_n)
    !ccff_clk_en |-> !ccff_head
  );

  a_count_max: assert property (
    @(posedge prog_clk) disable iff (!prog_reset_n)
    bit_count <= CNT_W'(CHAIN_LEN)
  );

  a_busy_done: assert property (
    @(posedge prog_clk) disable iff (!prog_reset_n)
    !(busy && done)
  );

endmodule

// File: tb/tb_fabric_ccff_loader.sv
// Directed bench for fabric_ccff_loader.
// Two instances: CHAIN_LEN=26 and CHAIN_LEN=8.
module tb_fabric_ccff_loader;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic tail;
  logic start1;
  logic abort1;
  logic tail1;

  logic       en0, head0, busy0, done0, par0;
  logic [4:0] bc0;
  logic       en1, head1, busy1, done1, par1;
  logic [3:0] bc1;

  int tests;
  int fails;

  logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'hC0};

  logic [31:0] head_bits;
  int n_shift, n_busy, n_done, n_acc, gap_bad, bc_drop;
  int done_cyc;
  logic ab_en;
  logic busy_after_ab;
  logic timed_out;

  fabric_ccff_loader_if #(.WORD_W(8)) if0 ();
  fabric_ccff_loader_if #(.WORD_W(8)) if1 ();

  fabric_ccff_loader #(.WORD_W(8), .CHAIN_LEN(26)) u0 (
    .prog_clk    (clk),
    .prog_reset_n(rst_n),
    .start       (start),
    .abort       (abort),
    .cfg         (if0),
    .ccff_head   (head0),
    .ccff_clk_en (en0),
    .ccff_tail   (tail),
    .busy        (busy0),
    .done        (done0),
    .tail_parity (par0),
    .bit_count   (bc0)
  );

  fabric_ccff_loader #(.WORD_W(8), .CHAIN_LEN(8)) u1 (
    .prog_clk    (clk),
    .prog_reset_n(rst_n),
    .start       (start1),
    .abort       (abort1),
    .cfg         (if1),
    .ccff_head   (head1),
    .ccff_clk_en (en1),
    .ccff_tail   (tail1),
    .busy        (busy1),
    .done        (done1),
    .tail_parity (par1),
    .bit_count   (bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one load on u0. cyc 0 is the start cycle.
  // gs/gl: valid gap window; ones: leading tail ones;
  // ab: abort cycle (-1 none); s2: extra start cycle (-1 none).
  task automatic drive_load(input int gs, input int gl, input int ones,
                            input int ab, input int s2);
    int wi;
    int cyc;
    int prev_bc;
    logic fin;
    head_bits = '0;
    n_shift = 0; n_busy = 0; n_done = 0; n_acc = 0;
    gap_bad = 0; bc_drop = 0; done_cyc = -1;
    ab_en = 1'b1; busy_after_ab = 1'b1;
    wi = 0; prev_bc = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 80) begin
      start = (cyc == 0) || (cyc == s2);
      abort = (cyc == ab);
      if0.cfg_valid = (wi < 4) && !(cyc >= gs && cyc < gs + gl);
      if0.cfg_data  = words[(wi < 4) ? wi : 3];
      tail = (n_shift < ones);
      @(negedge clk);
      if (cyc == ab) ab_en = en0;
      if (ab >= 0 && cyc == ab + 1) busy_after_ab = busy0;
      if (en0) begin
        head_bits = {head_bits[30:0], head0};
        n_shift++;
      end
      if (busy0) n_busy++;
      if (done0) begin
        n_done++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (if0.cfg_valid && if0.cfg_ready) begin
        n_acc++;
        wi++;
      end
      if (cyc >= gs && cyc < gs + gl && (!if0.cfg_ready || en0))
        gap_bad++;
      if (cyc >= 2 && int'(bc0) < prev_bc) bc_drop++;
      prev_bc = int'(bc0);
      if (ab >= 0 && cyc == ab + 3) fin = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    timed_out = !fin;
    start = 1'b0;
    abort = 1'b0;
    tail = 1'b0;
    if0.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({en0, head0, busy0, done0, par0, if0.cfg_ready} !== 6'b0) begin
      fails++;
      $display("FAIL reset_out0 got %b want 000000",
               {en0, head0, busy0, done0, par0, if0.cfg_ready});
    end
    tests++;
    if (bc0 !== 5'd0) begin
      fails++;
      $display("FAIL reset_bc0 got %0d want 0", bc0);
    end
    tests++;
    if ({en1, head1, busy1, done1, par1, if1.cfg_ready, bc1} !== 10'b0) begin
      fails++;
      $display("FAIL reset_u1 got %b want 0",
               {en1, head1, busy1, done1, par1, if1.cfg_ready, bc1});
    end
  endtask

  task automatic test_full_load();
    logic [25:0] exp_head;
    exp_head = {8'hA5, 8'h3C, 8'hFF, 2'b11};
    drive_load(-10, 0, 0, -1, -1);
    tests++;
    if (timed_out !== 1'b0) begin
      fails++;
      $display("FAIL full_timeout got %b want 0", timed_out);
    end
    tests++;
    if (n_shift !== 26) begin
      fails++;
      $display("FAIL full_shifts got %0d want 26", n_shift);
    end
    tests++;
    if (head_bits[25:0] !== exp_head) begin
      fails++;
      $display("FAIL full_head got %h want %h", head_bits[25:0], exp_head);
    end
    tests++;
    if (n_done !== 1 || done_cyc !== 31) begin
      fails++;
      $display("FAIL full_done got %0d@%0d want 1@31", n_done, done_cyc);
    end
    tests++;
    if (bc0 !== 5'd26) begin
      fails++;
      $display("FAIL full_bc got %0d want 26", bc0);
    end
    tests++;
    if (n_acc !== 4) begin
      fails++;
      $display("FAIL full_words got %0d want 4", n_acc);
    end
    tests++;
    if (n_busy !== 30) begin
      fails++;
      $display("FAIL full_busy got %0d want 30", n_busy);
    end
    tests++;
    if (par0 !== 1'b0) begin
      fails++;
      $display("FAIL full_parity got %b want 0", par0);
    end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || bc0 !== 5'd26) begin
      fails++;
      $display("FAIL full_hold got d%b b%b c%0d want d0 b0 c26",
               done0, busy0, bc0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gap();
    logic [25:0] exp_head;
    exp_head = {8'hA5, 8'h3C, 8'hFF, 2'b11};
    drive_load(19, 5, 0, -1, -1);
    tests++;
    if (gap_bad !== 0) begin
      fails++;
      $display("FAIL gap_quiet got %0d bad cycles want 0", gap_bad);
    end
    tests++;
    if (head_bits[25:0] !== exp_head || n_shift !== 26) begin
      fails++;
      $display("FAIL gap_head got %h/%0d want %h/26",
               head_bits[25:0], n_shift, exp_head);
    end
    tests++;
    if (bc0 !== 5'd26 || n_busy !== 35 || done_cyc !== 36) begin
      fails++;
      $display("FAIL gap_count got c%0d b%0d d%0d want c26 b35 d36",
               bc0, n_busy, done_cyc);
    end
  endtask

  task automatic test_parity();
    drive_load(-10, 0, 3, -1, -1);
    tests++;
    if (par0 !== 1'b1) begin
      fails++;
      $display("FAIL parity3 got %b want 1", par0);
    end
    drive_load(-10, 0, 4, -1, -1);
    tests++;
    if (par0 !== 1'b0) begin
      fails++;
      $display("FAIL parity4 got %b want 0", par0);
    end
  endtask

  task automatic test_abort();
    logic [25:0] exp_head;
    exp_head = {8'hA5, 8'h3C, 8'hFF, 2'b11};
    drive_load(-10, 0, 0, 14, -1);
    tests++;
    if (ab_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_en got %b want 0", ab_en);
    end
    tests++;
    if (busy_after_ab !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy got %b want 0", busy_after_ab);
    end
    tests++;
    if (n_done !== 0 || n_shift !== 11) begin
      fails++;
      $display("FAIL abort_done got d%0d s%0d want d0 s11", n_done, n_shift);
    end
    tests++;
    if (bc0 !== 5'd11 || head_bits[10:0] !== 11'b10100101001) begin
      fails++;
      $display("FAIL abort_bc got %0d/%b want 11/10100101001",
               bc0, head_bits[10:0]);
    end
    drive_load(-10, 0, 0, -1, -1);
    tests++;
    if (bc0 !== 5'd26 || head_bits[25:0] !== exp_head || n_done !== 1) begin
      fails++;
      $display("FAIL abort_reload got c%0d h%h d%0d want c26 h%h d1",
               bc0, head_bits[25:0], n_done, exp_head);
    end
  endtask

  task automatic test_start_in_shift();
    drive_load(-10, 0, 0, -1, 5);
    tests++;
    if (bc_drop !== 0 || bc0 !== 5'd26) begin
      fails++;
      $display("FAIL start_ignored got drops%0d c%0d want drops0 c26",
               bc_drop, bc0);
    end
    tests++;
    if (n_busy !== 30 || n_done !== 1) begin
      fails++;
      $display("FAIL start_ignored_busy got b%0d d%0d want b30 d1",
               n_busy, n_done);
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    if0.cfg_valid = 1'b1;
    if0.cfg_data = 8'hA5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    tests++;
    if (en0 !== 1'b1 || bc0 !== 5'd3) begin
      fails++;
      $display("FAIL midload_pre got en%b c%0d want en1 c3", en0, bc0);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({en0, head0, busy0, done0, par0, if0.cfg_ready, bc0} !== 11'b0) begin
      fails++;
      $display("FAIL midload_reset got %b want 0",
               {en0, head0, busy0, done0, par0, if0.cfg_ready, bc0});
    end
    if0.cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy0 !== 1'b0 || if0.cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL midload_idle got b%b r%b want b0 r0",
               busy0, if0.cfg_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_short_chain();
    int cyc;
    int shifts;
    int rdy;
    int dc;
    logic [7:0] hb;
    shifts = 0; rdy = 0; dc = -1; hb = '0;
    if1.cfg_data = 8'h81;
    if1.cfg_valid = 1'b1;
    for (cyc = 0; cyc < 14; cyc++) begin
      start1 = (cyc == 0);
      @(negedge clk);
      if (en1) begin
        hb = {hb[6:0], head1};
        shifts++;
      end
      if (if1.cfg_ready) rdy++;
      if (done1) dc = cyc;
      @(posedge clk);
      #1;
    end
    if1.cfg_valid = 1'b0;
    tests++;
    if (shifts !== 8 || hb !== 8'h81) begin
      fails++;
      $display("FAIL short_shift got %0d/%h want 8/81", shifts, hb);
    end
    tests++;
    if (dc !== 10) begin
      fails++;
      $display("FAIL short_done got %0d want 10", dc);
    end
    tests++;
    if (rdy !== 1 || bc1 !== 4'd8) begin
      fails++;
      $display("FAIL short_ready got r%0d c%0d want r1 c8", rdy, bc1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; tail = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; tail1 = 1'b0;
    if0.cfg_valid = 1'b0; if0.cfg_data = '0;
    if1.cfg_valid = 1'b0; if1.cfg_data = '0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_full_load();
    test_gap();
    test_parity();
    test_abort();
    test_start_in_shift();
    test_reset_mid_load();
    test_short_chain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
